// File: rtl/spi_stream_pkg.sv
// Shared types and elaboration helpers for the parallel SPI stream serializer.
// Contents:
//   state_t      - serializer FSM states
//   *_DEF        - default parameter values of the serializer
//   cnt_width()  - bits needed to hold 0..max_val (never less than 1)
//   max2()       - larger of two integers
//   clk_div_ok() - true when a full byte on the wire outlasts a prefetch
package spi_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int STREAM_COUNT_DEF   = 12;
  localparam int DATA_WIDTH_DEF     = 8;
  localparam int ADDRESS_NUMBER_DEF = 2250;
  localparam int READ_LATENCY_DEF   = 2;
  localparam int CLK_DIV_DEF        = 2;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The staged byte must land before the current byte's last SCK fall,
  // otherwise streaming would need a gap.
  function automatic bit clk_div_ok(input int clk_div, input int data_width,
                                    input int read_latency);
    return (clk_div >= 1) && (read_latency >= 1) &&
           (2 * clk_div * data_width > read_latency + 1);
  endfunction

endpackage

// File: rtl/spi_stream_serializer_sck_gen.sv
// spi_sck_gen: SPI mode-0 clock generator (idle low).
// Each half period lasts CLK_DIV clocks; the low half comes first after enable.
// Ports:
//   clk    in  clock
//   rst_n  in  async active-low reset
//   en     in  run; while low the counter is cleared and sck is held low
//   sck    out SPI clock
//   rise   out 1-cycle strobe: sck goes high on the next clock edge
//   fall   out 1-cycle strobe: sck goes low on the next clock edge
module spi_sck_gen #(
  parameter  int CLK_DIV = 2,
  localparam int DIV_W   = $clog2(CLK_DIV) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             sck_reg;
  logic             half_end;

  assign half_end = (div_cnt_reg == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      sck_reg     <= 1'b0;
    end else if (!en) begin
      div_cnt_reg <= '0;
      sck_reg     <= 1'b0;
    end else if (half_end) begin
      div_cnt_reg <= '0;
      sck_reg     <= ~sck_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign sck  = sck_reg;
  assign rise = en && half_end && !sck_reg;
  assign fall = en && half_end && sck_reg;

endmodule

// File: rtl/spi_stream_serializer.sv
// spi_stream_serializer: reads ADDRESS_NUMBER words of STREAM_COUNT byte lanes
// from a double-buffer read port and shifts each lane MSB-first onto its own
// MOSI line, all lanes sharing one mode-0 SCK. The next word is prefetched
// while the current byte is on the wire, so bytes stream without gaps.
// Optional macro SPI_STREAM_CS_EN: drive O_cs_n around the frame with a
// CLK_DIV-cycle lead and tail; without it O_cs_n is tied low.
// Ports:
//   I_clkb        in  clock
//   I_rst_n       in  async active-low reset
//   I_start       in  pulse: begin a frame (ignored while busy)
//   O_busy        out high from accepted start until frame done
//   O_frame_done  out 1-cycle pulse at end of frame
//   O_address     out read address to the buffer port
//   I_data_flat   in  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
//   O_sck         out common SPI clock, idle low
//   O_mosi        out one serial line per lane
//   O_cs_n        out chip select
module spi_stream_serializer
  import spi_stream_pkg::*;
#(
  parameter  int STREAM_COUNT   = STREAM_COUNT_DEF,
  parameter  int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter  int ADDRESS_NUMBER = ADDRESS_NUMBER_DEF,
  parameter  int READ_LATENCY   = READ_LATENCY_DEF,
  parameter  int CLK_DIV        = CLK_DIV_DEF,
  localparam int ADDR_W         = $clog2(ADDRESS_NUMBER),
  localparam int LANES_W        = STREAM_COUNT * DATA_WIDTH
) (
  input  logic                    I_clkb,
  input  logic                    I_rst_n,
  input  logic                    I_start,
  output logic                    O_busy,
  output logic                    O_frame_done,
  output logic [ADDR_W-1:0]       O_address,
  input  logic [LANES_W-1:0]      I_data_flat,
  output logic                    O_sck,
  output logic [STREAM_COUNT-1:0] O_mosi,
  output logic                    O_cs_n
);

  localparam int BIT_W     = cnt_width(DATA_WIDTH - 1);
  // One counter serves PRIME latency, staging latency (saturates at
  // READ_LATENCY+1) and the chip-select tail.
  localparam int WAIT_W    = cnt_width(max2(READ_LATENCY + 1, CLK_DIV));
  localparam int LAST_ADDR = ADDRESS_NUMBER - 1;

  if (!clk_div_ok(CLK_DIV, DATA_WIDTH, READ_LATENCY)) begin : g_bad_cfg
    $error("spi_stream_serializer: need 2*CLK_DIV*DATA_WIDTH > READ_LATENCY+1");
  end

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  address_reg, address_next;
  logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic               last_byte_reg, last_byte_next;
  logic               last_bit_reg, last_bit_next;
  logic [LANES_W-1:0] shift_reg, shift_next;
  logic [LANES_W-1:0] staging_reg, staging_next;
  logic               byte_begin;
  logic               done_now;
  logic               sck_rise, sck_fall;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk   (I_clkb),
    .rst_n (I_rst_n),
    .en    (state_reg == SHIFT),
    .sck   (O_sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

`ifdef SPI_STREAM_CS_EN
  // DONE holds CS low for CLK_DIV cycles after the last fall, then releases.
  assign done_now = (wait_cnt_reg == WAIT_W'(CLK_DIV));
  assign O_cs_n   = !((state_reg == SHIFT) || ((state_reg == DONE) && !done_now));
`else
  assign done_now = 1'b1;
  assign O_cs_n   = 1'b0;
`endif

  always_ff @(posedge I_clkb or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_reg     <= IDLE;
      address_reg   <= '0;
      bit_cnt_reg   <= '0;
      wait_cnt_reg  <= '0;
      last_byte_reg <= 1'b0;
      last_bit_reg  <= 1'b0;
      shift_reg     <= '0;
      staging_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      address_reg   <= address_next;
      bit_cnt_reg   <= bit_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      last_byte_reg <= last_byte_next;
      last_bit_reg  <= last_bit_next;
      shift_reg     <= shift_next;
      staging_reg   <= staging_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    address_next   = address_reg;
    bit_cnt_next   = bit_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    last_byte_next = last_byte_reg;
    last_bit_next  = last_bit_reg;
    shift_next     = shift_reg;
    staging_next   = staging_reg;
    byte_begin     = 1'b0;

    case (state_reg)
      IDLE: begin
        wait_cnt_next = '0;
        if (I_start) state_next = PRIME;
      end

      PRIME: begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
        if (wait_cnt_reg == WAIT_W'(READ_LATENCY - 1)) begin
          shift_next = I_data_flat;
          byte_begin = 1'b1;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (wait_cnt_reg <= WAIT_W'(READ_LATENCY)) wait_cnt_next = wait_cnt_reg + 1'b1;
        if (wait_cnt_reg == WAIT_W'(READ_LATENCY)) staging_next = I_data_flat;
        // End-of-byte is decided at the rise so the fall only tests a flop.
        if (sck_rise) last_bit_next = (bit_cnt_reg == BIT_W'(DATA_WIDTH - 1));
        if (sck_fall) begin
          last_bit_next = 1'b0;
          if (last_bit_reg) begin
            bit_cnt_next = '0;
            if (last_byte_reg) begin
              shift_next    = '0;
              wait_cnt_next = '0;
              state_next    = DONE;
            end else begin
              shift_next = staging_reg;
              byte_begin = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            for (int i = 0; i < STREAM_COUNT; i++) begin
              shift_next[i*DATA_WIDTH +: DATA_WIDTH] =
                {shift_reg[i*DATA_WIDTH +: DATA_WIDTH-1], 1'b0};
            end
          end
        end
      end

      DONE: begin
        if (done_now) begin
          state_next     = IDLE;
          address_next   = '0;
          last_byte_next = 1'b0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase

    // A byte going onto the wire launches the read for the following one;
    // at the last address the read is not advanced and the byte is flagged last.
    if (byte_begin) begin
      wait_cnt_next = '0;
      if (address_reg == ADDR_W'(LAST_ADDR)) last_byte_next = 1'b1;
      else                                   address_next   = address_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < STREAM_COUNT; gi++) begin : g_mosi
    assign O_mosi[gi] = shift_reg[gi*DATA_WIDTH + DATA_WIDTH - 1];
  end

  assign O_frame_done = (state_reg == DONE) && done_now;
  assign O_busy       = (state_reg != IDLE) && !O_frame_done;
  assign O_address    = address_reg;

endmodule

// File: tb/tb_spi_stream_serializer.sv
// Bench for spi_stream_serializer: frame scenarios from a table plus a reset
// sequence; a scoreboard queue holds the expected lanes of every address and
// a negedge monitor reassembles bytes from MOSI on SCK rises.
module tb_spi_stream_serializer;

  localparam int SC  = 12;
  localparam int DW  = 8;
  localparam int AN  = 40;
  localparam int RL  = 2;
`ifdef SPI_STREAM_CS_EN
  localparam int CD = 3;
  localparam logic CS_IDLE = 1'b1;
`else
  localparam int CD = 2;
  localparam logic CS_IDLE = 1'b0;
`endif
  localparam int AW    = $clog2(AN);
  localparam int LW    = SC * DW;
  localparam int LIMIT = 2 * CD * DW * AN + 100;

  typedef struct {
    bit         spam;
    int         abort_at;
    int         exp_done;
    logic [7:0] salt;
  } vec_t;

  logic          clk, rst_n, start;
  logic          busy, frame_done, sck, cs_n;
  logic [AW-1:0] address, addr_d;
  logic [LW-1:0] data_flat;
  logic [SC-1:0] mosi;

  int            n_cmp, n_err, done_cnt, byte_cnt;
  logic [7:0]    salt;
  logic [LW-1:0] exp_q[$];

  spi_stream_serializer #(
    .STREAM_COUNT(SC), .DATA_WIDTH(DW), .ADDRESS_NUMBER(AN),
    .READ_LATENCY(RL), .CLK_DIV(CD)
  ) dut (
    .I_clkb(clk), .I_rst_n(rst_n), .I_start(start),
    .O_busy(busy), .O_frame_done(frame_done), .O_address(address),
    .I_data_flat(data_flat), .O_sck(sck), .O_mosi(mosi), .O_cs_n(cs_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [LW-1:0] lanes_of(input int a, input logic [7:0] s);
    logic [LW-1:0] r;
    logic [3:0]    a4;
    a4 = a[3:0];
    r  = '0;
    for (int i = 0; i < SC; i++) r[i*DW +: DW] = {a4, 4'(i)} ^ s;
    return r;
  endfunction

  // Upstream buffer: registered address then registered data (2-cycle latency).
  always @(posedge clk) begin
    addr_d    <= address;
    data_flat <= lanes_of(int'(addr_d), salt);
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: byte scoreboard, SCK phase lengths, address steps, frame end.
  initial begin
    int            cyc, run_len, frame_rises, bit_idx, first_high, last_low;
    int            cs_fall, cs_rise;
    logic          prev_sck, prev_cs, cs_high_seen;
    logic [AW-1:0] prev_addr, max_addr;
    logic [LW-1:0] acc, want;
    cyc = 0; run_len = 0; frame_rises = 0; bit_idx = 0; first_high = 0;
    last_low = 0; cs_fall = 0; cs_rise = 0; prev_sck = 0; prev_cs = CS_IDLE;
    cs_high_seen = 0; prev_addr = '0; max_addr = '0; acc = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        run_len = 0; frame_rises = 0; bit_idx = 0; acc = '0;
        prev_sck = 0; prev_cs = CS_IDLE; prev_addr = '0; max_addr = '0;
        continue;
      end
      if (sck && !prev_sck) begin
        if (frame_rises == 0) first_high = cyc;
        else check("sck_low_phase", run_len, CD);
        frame_rises++;
        run_len = 1;
        for (int i = 0; i < SC; i++) acc[i*DW +: DW] = {acc[i*DW +: DW-1], mosi[i]};
        bit_idx++;
        if (bit_idx == DW) begin
          bit_idx = 0;
          check("byte_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check($sformatf("lanes_byte%0d", byte_cnt), acc, want);
            byte_cnt++;
          end
        end
      end else if (!sck && prev_sck) begin
        check("sck_high_phase", run_len, CD);
        last_low = cyc;
        run_len  = 1;
      end else begin
        run_len++;
      end
`ifdef SPI_STREAM_CS_EN
      if (!cs_n && prev_cs) cs_fall = cyc;
      if (cs_n && !prev_cs) cs_rise = cyc;
`else
      if (cs_n) cs_high_seen = 1;
`endif
      if (address != prev_addr) begin
        check("addr_step", address, busy ? int'(prev_addr) + 1 : 0);
        if (address > max_addr) max_addr = address;
      end
      if (frame_done) begin
        done_cnt++;
        check("busy_at_done", busy, 0);
        check("rises_per_frame", frame_rises, DW * AN);
        check("max_addr", max_addr, AN - 1);
`ifdef SPI_STREAM_CS_EN
        check("cs_lead", first_high - cs_fall, CD);
        check("cs_tail", cs_rise - last_low, CD);
        check("done_on_cs_rise", cyc - cs_rise, 0);
`else
        check("done_after_fall", cyc - last_low, 0);
        check("cs_n_const", cs_high_seen, 0);
`endif
        frame_rises = 0;
        max_addr    = '0;
      end
      prev_sck  = sck;
      prev_cs   = cs_n;
      prev_addr = address;
    end
  end

  task automatic run_vec(input vec_t v);
    bit finished, busy_dropped;
    salt = v.salt; done_cnt = 0; byte_cnt = 0;
    exp_q.delete();
    for (int a = 0; a < AN; a++) exp_q.push_back(lanes_of(a, v.salt));
    start = 1'b1;
    @(negedge clk);
    start = v.spam;
    check("busy_rise", busy, 1);
    finished = 0; busy_dropped = 0;
    for (int c = 0; c < LIMIT && !finished; c++) begin
      @(negedge clk);
      if (frame_done) finished = 1;
      else if (!busy) busy_dropped = 1;
      if (v.abort_at >= 0 && int'(address) == v.abort_at) begin
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {busy, frame_done, address, sck, mosi, cs_n},
              {1'b0, 1'b0, {AW{1'b0}}, 1'b0, {SC{1'b0}}, CS_IDLE});
        finished = 1;
      end
    end
    start = 1'b0;
    check("frame_end_reached", finished, 1);
    if (v.abort_at >= 0) begin
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (12) @(negedge clk);
    check("done_count", done_cnt, v.exp_done);
    check("busy_idle", busy, 0);
    check("addr_idle", address, 0);
    if (v.abort_at < 0) begin
      check("bytes_per_frame", byte_cnt, AN);
      check("busy_held", busy_dropped, 0);
    end
  endtask

  initial begin
    vec_t vecs[4];
    vecs[0] = '{spam: 1'b0, abort_at: -1, exp_done: 1, salt: 8'h00};
    vecs[1] = '{spam: 1'b1, abort_at: -1, exp_done: 1, salt: 8'hA5};
    vecs[2] = '{spam: 1'b0, abort_at: 37, exp_done: 0, salt: 8'h3C};
    vecs[3] = '{spam: 1'b0, abort_at: -1, exp_done: 1, salt: 8'hFF};
    n_cmp = 0; n_err = 0; done_cnt = 0; byte_cnt = 0; salt = 8'h00;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, frame_done, address, sck, mosi, cs_n},
          {1'b0, 1'b0, {AW{1'b0}}, 1'b0, {SC{1'b0}}, CS_IDLE});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      $display("vector %0d: spam=%0d abort_at=%0d salt=%0h", k, vecs[k].spam,
               vecs[k].abort_at, vecs[k].salt);
      run_vec(vecs[k]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
